// File: rtl/tpu_package.sv
// Shared types and constants for the accumulator read path.
package tpu_package;

    localparam int unsigned MUL_SIZE   = 32;
    localparam int unsigned ACC_DEPTH  = 128;
    localparam int unsigned ACC_ADDR_W = $clog2(ACC_DEPTH);
    // Wide enough to count the longest diagonal command (len + MUL_SIZE steps).
    localparam int unsigned STEP_W     = $clog2(ACC_DEPTH + MUL_SIZE);

    typedef logic [31:0]             res_t;
    typedef logic [ACC_ADDR_W-1:0]   acc_addr_t;
    typedef logic [STEP_W-1:0]       step_t;
    typedef logic [MUL_SIZE-1:0]     lane_mask_t;
    typedef acc_addr_t [MUL_SIZE-1:0] acc_addr_vec_t;
    typedef res_t [MUL_SIZE-1:0]     res_vec_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DIAG   = 1'b1
    } acc_rd_mode;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } acc_rd_state_e;

    typedef struct packed {
        res_vec_t   data;
        lane_mask_t mask;
        logic       last;
    } acc_beat_t;

    // Per-bank starting row for the diagonal walk: bank j reads base - j + k at step k,
    // so each entry carries the bank's row offset j already subtracted (mod ACC_DEPTH).
    function automatic acc_addr_vec_t diag_addr_LUT(input acc_addr_t base);
        acc_addr_vec_t lut;
        for (int j = 0; j < MUL_SIZE; j++) begin
            lut[j] = base - acc_addr_t'(j);
        end
        return lut;
    endfunction

endpackage

// File: rtl/acc_rd_skid_fifo.sv
// Two-entry beat FIFO with same-cycle bypass when empty, so a beat returning from the
// banks can leave in the cycle it arrives. count_o reports stored entries only.
module acc_rd_skid_fifo
    import tpu_package::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  res_vec_t   push_data_i,
    input  lane_mask_t push_mask_i,
    input  logic       push_last_i,
    input  logic       pop_ready_i,
    output logic       valid_o,
    output res_vec_t   data_o,
    output lane_mask_t mask_o,
    output logic       last_o,
    output logic [1:0] count_o
);

    acc_beat_t  mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    acc_beat_t  push_beat, head;
    logic       empty, wr_en, rd_en;

    // Head selection, bypass and occupancy update.
    always_comb begin
        push_beat.data = push_data_i;
        push_beat.mask = push_mask_i;
        push_beat.last = push_last_i;
        empty          = (count_q == 2'd0);
        if (!empty) begin
            head = mem_q[rd_ptr_q];
        end else if (push_i) begin
            head = push_beat;
        end else begin
            head = '0;
        end
        valid_o = !empty || push_i;
        // A push into an empty FIFO that is taken right away never gets stored.
        wr_en   = push_i && !(empty && pop_ready_i);
        rd_en   = !empty && pop_ready_i;
        count_d = count_q + {1'b0, wr_en} - {1'b0, rd_en};
        data_o  = head.data;
        mask_o  = head.mask;
        last_o  = head.last;
        count_o = count_q;
    end

    // Storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: rtl/acc_reader.sv
// Accumulator read controller: walks a command over the banks (straight or diagonally
// skewed) and streams one lane-masked beat per step under a two-beat credit limit.
module acc_reader
    import tpu_package::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  acc_addr_t     req_base,
    input  acc_addr_t     req_len,
    input  acc_rd_mode    req_mode,
    output lane_mask_t    acc_rd_en,
    output acc_addr_vec_t acc_rd_addr,
    input  res_vec_t      acc_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output res_vec_t      out_data,
    output lane_mask_t    out_lane_vld,
    output logic          out_last
);

    acc_rd_state_e state_q, state_d;
    acc_addr_t     base_q, base_d;
    acc_addr_t     len_q, len_d;
    acc_rd_mode    mode_q, mode_d;
    step_t         k_q, k_d;
    logic          inflight_q;
    lane_mask_t    mask_q;
    logic          last_q;

    logic [1:0]    fifo_count, occupancy;
    logic          credit_ok, issue, final_step, pop, drained;
    step_t         last_step;
    acc_addr_vec_t diag_base;
    res_vec_t      push_data;

    // Credit and step bookkeeping.
    always_comb begin
        diag_base  = diag_addr_LUT(base_q);
        // FIFO holds at most 2 and in-flight at most 1, so the sum fits 2 bits.
        occupancy  = fifo_count + {1'b0, inflight_q};
        credit_ok  = (occupancy < 2'd2);
        issue      = (state_q == StRun) && credit_ok;
        last_step  = (mode_q == DIAG) ? step_t'(len_q) + step_t'(MUL_SIZE - 1) : step_t'(len_q);
        final_step = (k_q == last_step);
        pop        = out_valid && out_ready;
        // Everything outstanding leaves this cycle; lets req_ready rise right after the last beat.
        drained    = (occupancy == {1'b0, pop});
    end

    // Per-bank read enables and addresses for the current step.
    always_comb begin
        acc_rd_en   = '0;
        acc_rd_addr = '0;
        if (issue) begin
            for (int j = 0; j < MUL_SIZE; j++) begin
                if (mode_q == NORMAL) begin
                    acc_rd_en[j]   = 1'b1;
                    acc_rd_addr[j] = base_q + k_q[ACC_ADDR_W-1:0];
                end else if ((k_q >= step_t'(j)) && ((k_q - step_t'(j)) <= step_t'(len_q))) begin
                    acc_rd_en[j]   = 1'b1;
                    acc_rd_addr[j] = diag_base[j] + k_q[ACC_ADDR_W-1:0];
                end
            end
        end
    end

    // Command FSM next-state.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        mode_d    = mode_q;
        k_d       = k_q;
        req_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d  = req_base;
                    len_d   = req_len;
                    mode_d  = req_mode;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    k_d = k_q + step_t'(1);
                    if (final_step) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            mode_q  <= NORMAL;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

    // Read-return pipe: lane mask and last flag ride alongside the bank latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            mask_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            mask_q     <= acc_rd_en;
            last_q     <= issue && final_step;
        end
    end

    // Zero the lanes that were not read for this beat.
    always_comb begin
        for (int j = 0; j < MUL_SIZE; j++) begin
            push_data[j] = mask_q[j] ? acc_rd_data[j] : '0;
        end
    end

    acc_rd_skid_fifo u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .push_mask_i (mask_q),
        .push_last_i (last_q),
        .pop_ready_i (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .mask_o      (out_lane_vld),
        .last_o      (out_last),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_acc_reader.sv
// Randomized self-checking bench for acc_reader with a behavioural bank and beat model.
module tb_acc_reader;
    import tpu_package::*;

    typedef struct packed {
        res_vec_t   data;
        lane_mask_t vld;
        logic       last;
    } tb_beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    acc_addr_t     req_base;
    acc_addr_t     req_len;
    acc_rd_mode    req_mode;
    lane_mask_t    acc_rd_en;
    acc_addr_vec_t acc_rd_addr;
    res_vec_t      acc_rd_data;
    logic          out_valid;
    logic          out_ready;
    res_vec_t      out_data;
    lane_mask_t    out_lane_vld;
    logic          out_last;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor-owned observations.
    tb_beat_t  got_q[$];
    acc_addr_t addr0_q[$];
    int        cyc = 0, hs_count = 0, hs_cyc = -1, first_en_cyc = -1, first_vld_cyc = -1;
    int        last_hs_cyc = -1, ready_ret_cyc = -1, steps = 0, beats = 0, max_out = 0;
    int        stall_viol = 0, tot_valid = 0;
    bit        prev_stall = 1'b0;
    tb_beat_t  prev_beat;

    tb_beat_t  exp_q[$];

    always #5 clk = ~clk;

    acc_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_base     (req_base),
        .req_len      (req_len),
        .req_mode     (req_mode),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lane_vld (out_lane_vld),
        .out_last     (out_last)
    );

    // Bank model: one-cycle read latency, garbage on banks that were not enabled.
    always @(posedge clk) begin
        for (int j = 0; j < MUL_SIZE; j++) begin
            if (acc_rd_en[j]) acc_rd_data[j] <= {j[15:0], 9'b0, acc_rd_addr[j]};
            else              acc_rd_data[j] <= $urandom;
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        tb_beat_t cur;
        cyc++;
        cur.data = out_data;
        cur.vld  = out_lane_vld;
        cur.last = out_last;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                hs_count++;
                hs_cyc = cyc;
                first_en_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1; ready_ret_cyc = -1;
                steps = 0; beats = 0; max_out = 0; stall_viol = 0;
                got_q.delete();
                addr0_q.delete();
            end else if (req_ready && hs_cyc >= 0 && ready_ret_cyc < 0) begin
                ready_ret_cyc = cyc;
            end
            if (|acc_rd_en) begin
                steps++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                if (acc_rd_en[0]) addr0_q.push_back(acc_rd_addr[0]);
            end
            if (out_valid) begin
                tot_valid++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (prev_stall && !(out_valid && cur == prev_beat)) stall_viol++;
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                beats++;
                last_hs_cyc = cyc;
            end
            if (steps - beats > max_out) max_out = steps - beats;
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
        end
    end

    // Reference beat stream built straight from the command semantics.
    function automatic void build_exp(input acc_addr_t base, input acc_addr_t len,
                                      input acc_rd_mode mode);
        int n, r;
        tb_beat_t b;
        exp_q.delete();
        n = (mode == DIAG) ? int'(len) + 32 : int'(len) + 1;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 32; j++) begin
                r = (mode == NORMAL) ? k : k - j;
                b.vld[j]  = (mode == NORMAL) || (r >= 0 && r <= int'(len));
                b.data[j] = b.vld[j] ? {j[15:0], 9'b0, acc_addr_t'((int'(base) + r) % 128)} : 32'h0;
            end
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Locates the first differing beat and lane (lane -1 when only mask/last differ).
    function automatic void find_mismatch(output int idx, output int lane);
        int n;
        idx = -1; lane = -1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                idx = i;
                for (int j = 0; j < 32; j++)
                    if (got_q[i].data[j] !== exp_q[i].data[j] && lane < 0) lane = j;
                break;
            end
        end
    endfunction

    task automatic run_cmd(input acc_addr_t base, input acc_addr_t len, input acc_rd_mode mode,
                           input int rdy, output bit ok);
        int hs0, n;
        bit tog;
        build_exp(base, len, mode);
        n   = exp_q.size();
        hs0 = hs_count;
        ok  = 1'b0;
        tog = 1'b1;
        @(posedge clk); #1;
        req_base = base; req_len = len; req_mode = mode; req_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            @(posedge clk); #1;
            if (hs_count != hs0) req_valid = 1'b0;
            case (rdy)
                0:       out_ready = 1'b1;
                1:       begin tog = ~tog; out_ready = tog; end
                default: out_ready = 1'($urandom);
            endcase
            if (hs_count != hs0 && got_q.size() >= n && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        req_base = '0; req_len = '0; req_mode = NORMAL;
        #2;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if ({acc_rd_en, acc_rd_addr, out_valid, out_data, out_lane_vld, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: en=%h valid=%b vld=%h last=%b, expected all 0",
                     acc_rd_en, out_valid, out_lane_vld, out_last);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_normal_short();
        bit ok; int idx, lane;
        run_cmd(7'd0, 7'd3, NORMAL, 0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL normal_short timeout: got %0d beats expected 4", got_q.size()); end
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL normal_short count: got %0d expected 4", got_q.size()); end
        find_mismatch(idx, lane);
        n_checks++;
        if (idx >= 0) begin
            n_fail++;
            $display("FAIL normal_short content: beat %0d vld=%h last=%b expected vld=%h last=%b",
                     idx, got_q[idx].vld, got_q[idx].last, exp_q[idx].vld, exp_q[idx].last);
        end
        n_checks++;
        if (first_en_cyc - hs_cyc != 1) begin
            n_fail++; $display("FAIL normal_short rd_en latency: got %0d expected 1", first_en_cyc - hs_cyc);
        end
        n_checks++;
        if (first_vld_cyc - hs_cyc != 2) begin
            n_fail++; $display("FAIL normal_short out_valid latency: got %0d expected 2", first_vld_cyc - hs_cyc);
        end
        n_checks++;
        if (last_hs_cyc - first_vld_cyc != 3) begin
            n_fail++; $display("FAIL normal_short throughput: got span %0d expected 3", last_hs_cyc - first_vld_cyc);
        end
        n_checks++;
        if (ready_ret_cyc - last_hs_cyc != 1) begin
            n_fail++; $display("FAIL normal_short req_ready return: got %0d expected 1", ready_ret_cyc - last_hs_cyc);
        end
    endtask

    task automatic test_diag();
        bit ok; int idx, lane;
        run_cmd(7'd10, 7'd1, DIAG, 0, ok);
        n_checks++;
        if (!ok || got_q.size() != 33) begin
            n_fail++; $display("FAIL diag count: got %0d expected 33 (ok=%b)", got_q.size(), ok);
        end
        find_mismatch(idx, lane);
        if (lane < 0) lane = 0;
        n_checks++;
        if (idx >= 0) begin
            n_fail++;
            $display("FAIL diag content: beat %0d lane %0d got %h vld=%h last=%b expected %h vld=%h last=%b",
                     idx, lane, got_q[idx].data[lane], got_q[idx].vld, got_q[idx].last,
                     exp_q[idx].data[lane], exp_q[idx].vld, exp_q[idx].last);
        end
        n_checks++;
        if (ready_ret_cyc - last_hs_cyc != 1) begin
            n_fail++; $display("FAIL diag req_ready return: got %0d expected 1", ready_ret_cyc - last_hs_cyc);
        end
    endtask

    task automatic test_wrap();
        bit ok; int idx, lane;
        acc_addr_t want [4];
        want[0] = 7'd126; want[1] = 7'd127; want[2] = 7'd0; want[3] = 7'd1;
        run_cmd(7'd126, 7'd3, NORMAL, 0, ok);
        n_checks++;
        if (addr0_q.size() != 4) begin
            n_fail++; $display("FAIL wrap address count: got %0d expected 4", addr0_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (addr0_q[i] !== want[i]) begin
                    n_fail++; $display("FAIL wrap address %0d: got %0d expected %0d", i, addr0_q[i], want[i]);
                end
            end
        end
        find_mismatch(idx, lane);
        n_checks++;
        if (!ok || idx >= 0 || got_q.size() != 4) begin
            n_fail++; $display("FAIL wrap content: first bad beat %0d, got %0d beats expected 4", idx, got_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok; int idx, lane;
        acc_addr_t base;
        base = acc_addr_t'($urandom);
        run_cmd(base, 7'd15, NORMAL, 1, ok);
        n_checks++;
        if (!ok || got_q.size() != 16) begin
            n_fail++; $display("FAIL backpressure count: got %0d expected 16 (ok=%b)", got_q.size(), ok);
        end
        find_mismatch(idx, lane);
        if (lane < 0) lane = 0;
        n_checks++;
        if (idx >= 0) begin
            n_fail++;
            $display("FAIL backpressure content: beat %0d lane %0d got %h expected %h",
                     idx, lane, got_q[idx].data[lane], exp_q[idx].data[lane]);
        end
        n_checks++;
        if (max_out > 2) begin n_fail++; $display("FAIL backpressure credit: got %0d outstanding expected <= 2", max_out); end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL backpressure stability: got %0d changes expected 0", stall_viol); end
    endtask

    task automatic test_reset_mid_run();
        bit ok; int hs0, tv0, idx, lane;
        hs0 = hs_count;
        @(posedge clk); #1;
        req_base = acc_addr_t'($urandom); req_len = 7'd19; req_mode = NORMAL;
        req_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (hs_count != hs0) req_valid = 1'b0;
            if (hs_count != hs0 && beats >= 5) break;
        end
        req_valid = 1'b0;
        n_checks++;
        if (hs_count == hs0 || beats < 5) begin
            n_fail++; $display("FAIL reset_mid reach beat 5: got %0d beats expected 5", beats);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_rd_en, acc_rd_addr, out_valid, out_data, out_lane_vld, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: en=%h valid=%b vld=%h last=%b, expected all 0",
                     acc_rd_en, out_valid, out_lane_vld, out_last);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid req_ready in reset: got %b expected 1", req_ready); end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tv0 = tot_valid;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (tot_valid != tv0) begin n_fail++; $display("FAIL reset_mid stale beats: got %0d expected 0", tot_valid - tv0); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid req_ready after release: got %b expected 1", req_ready); end
        run_cmd(7'd0, 7'd0, DIAG, 0, ok);
        find_mismatch(idx, lane);
        n_checks++;
        if (!ok || got_q.size() != 32 || idx >= 0) begin
            n_fail++; $display("FAIL reset_mid follow-up diag: got %0d beats expected 32, first bad beat %0d", got_q.size(), idx);
        end
    endtask

    task automatic test_full_depth();
        bit ok; int idx, lane, nlast, lpos;
        run_cmd(7'd0, 7'd127, NORMAL, 0, ok);
        n_checks++;
        if (!ok || got_q.size() != 128) begin
            n_fail++; $display("FAIL full_depth count: got %0d expected 128 (ok=%b)", got_q.size(), ok);
        end
        find_mismatch(idx, lane);
        n_checks++;
        if (idx >= 0) begin n_fail++; $display("FAIL full_depth content: first bad beat %0d expected none", idx); end
        nlast = 0; lpos = -1;
        foreach (got_q[i]) if (got_q[i].last) begin nlast++; lpos = i; end
        n_checks++;
        if (nlast != 1 || lpos != 127) begin
            n_fail++; $display("FAIL full_depth last: got %0d flags at beat %0d expected 1 at beat 127", nlast, lpos);
        end
    endtask

    task automatic test_random();
        bit ok; int idx, lane;
        acc_addr_t base, len;
        acc_rd_mode mode;
        for (int it = 0; it < 6; it++) begin
            base = acc_addr_t'($urandom);
            len  = acc_addr_t'($urandom_range(0, 40));
            mode = acc_rd_mode'($urandom_range(0, 1));
            run_cmd(base, len, mode, 2, ok);
            find_mismatch(idx, lane);
            if (lane < 0) lane = 0;
            n_checks++;
            if (!ok || got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL random[%0d] count: got %0d expected %0d", it, got_q.size(), exp_q.size());
            end
            n_checks++;
            if (idx >= 0) begin
                n_fail++;
                $display("FAIL random[%0d] content: beat %0d lane %0d got %h vld=%h expected %h vld=%h",
                         it, idx, lane, got_q[idx].data[lane], got_q[idx].vld,
                         exp_q[idx].data[lane], exp_q[idx].vld);
            end
            n_checks++;
            if (max_out > 2 || stall_viol != 0) begin
                n_fail++; $display("FAIL random[%0d] flow: got outstanding %0d, stall changes %0d expected <=2 and 0",
                                   it, max_out, stall_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_short();
        test_diag();
        test_wrap();
        test_backpressure();
        test_reset_mid_run();
        test_full_depth();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
